dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer for the 32-word data memory. It shares the memory between requester port 0 (core load/store unit) and requester port 1 (debug/DMA). Each cycle it grants at most one request over a valid/ready handshake and drives the memory write and read ports. Read data is registered back to the owning port one cycle later. A lock mechanism gives one port exclusive access for read-modify-write sequences.

## Interface
- `ADDR_W`, default 5: memory word address width.
- `DATA_W`, default 32: data width.
- `LOCK_TIMEOUT`, default 16: number of consecutive idle owner cycles before a lock is forcibly released. A value of 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pN_req_valid`  in  1  request present (N = 0, 1).
- `pN_req_ready`  out  1  request accepted this cycle.
- `pN_req_we`  in  1  1 = write, 0 = read.
- `pN_req_lock`  in  1  keep exclusive ownership after this request.
- `pN_req_addr`  in  ADDR_W  word address.
- `pN_req_wdata`  in  DATA_W  write data.
- `pN_rsp_valid`  out  1  one-cycle response strobe.
- `pN_rsp_rdata`  out  DATA_W  read data; 0 for write responses.
- `mem_we`  out  1  memory write enable.
- `mem_write_addr`  out  ADDR_W  memory write address.
- `mem_write_data`  out  DATA_W  memory write data.
- `mem_read_addr`  out  ADDR_W  memory read address.
- `mem_read_data`  in  DATA_W  combinational memory read data.
- `lock_abort`  out  1  one-cycle pulse when a lock times out.

## Operation
- A request is accepted when `pN_req_valid && pN_req_ready`. At most one `pN_req_ready` is high per cycle, and it is high only for a port whose valid is high.
- State machine states: IDLE, LOCK0, LOCK1. Reset state is IDLE.
- In IDLE:
  - A single valid port is granted.
  - If both ports are valid, the priority rule applies (see Configuration).
  - An accepted request with `req_lock=1` moves the state to LOCKn, where n is the accepting port.
- In LOCKn:
  - Only port n can be granted. The other port sees ready=0 regardless of its valid.
  - An accepted request from n with `req_lock=0` returns the state to IDLE.
  - An accepted request from n with `req_lock=1` stays in LOCKn.
- Lock timeout:
  - An idle counter increments on every LOCKn cycle in which port n's valid is low. It clears on any owner valid and on entering LOCKn.
  - When the counter reaches LOCK_TIMEOUT, the state returns to IDLE on that edge and `lock_abort` is high for the following cycle.
  - With `LOCK_TIMEOUT=0` the counter never fires.
- Accepted write:
  - `mem_we=1`.
  - `mem_write_addr` and `mem_write_data` carry the request's address and write data in the same cycle.
- Accepted read:
  - `mem_read_addr` carries the request's address.
  - `mem_read_data` is captured into `pN_rsp_rdata` at the edge.
- When nothing is accepted:
  - `mem_we=0`.
  - `mem_write_addr`, `mem_write_data` and `mem_read_addr` are driven to 0.
- Ports with no response this cycle: rsp_rdata holds its last value.

## Timing
- Grant is combinational: ready is asserted in the same cycle as valid when granted.
- Response latency is exactly 1 cycle: `pN_rsp_valid` is high for one cycle after every accept, for both reads and writes.
- Accepts may occur every cycle, including alternating between ports, with no bubble.
- A read on the cycle after a write to the same address returns the new data, because the memory updates at the edge.
- Reset values:
  - all `pN_req_ready` = 0 while `rst_n` is low;
  - `pN_rsp_valid` = 0 and `pN_rsp_rdata` = 0;
  - `mem_we` = 0 and all memory address/data outputs = 0;
  - `lock_abort` = 0;
  - state IDLE, idle counter 0, last-grant register = 1.
- Reset asserted mid-lock or mid-response clears everything asynchronously. A pending response is dropped.
- When the timeout edge coincides with an owner valid, the valid wins. The counter clears and the request is accepted.

## Configuration
- Macro `DMEM_ARB_ROUND_ROBIN_EN`:
  - Defined: IDLE contention grants the port that was not granted last. The last-grant register updates on every accept.
  - Undefined: port 0 always wins contention. The last-grant register is not implemented.
- The lock state machine is unaffected by this macro.

## Test plan
- **Single-port write then read.** Port 0 writes addr 3 = 0xDEADBEEF, then reads addr 3 on the next cycle. Required response: `mem_we` is high one cycle with addr 3; `p0_rsp_valid` pulses twice; the second response has rdata 0xDEADBEEF.
- **Contention.** Both ports read every cycle for 4 cycles.
  - With the macro defined: grants go 0,1,0,1.
  - Without the macro: grants go 0,0,0,0 and `p1_req_ready` stays 0.
- **Lock exclusion.** Port 1 reads addr 7 with lock=1, then port 0 requests continuously. Port 1 then writes addr 7 with lock=0. Required response: `p0_req_ready` stays 0 until the cycle after port 1's unlocking write is accepted; port 0 is granted in that next cycle.
- **Lock timeout.** `LOCK_TIMEOUT=16`; port 0 locks, then goes idle. Required response: `lock_abort` pulses 17 cycles after the lock accept; port 1 is granted on the following cycle.
- **Reset mid-lock.** Pulse `rst_n` low during LOCK1 with a response pending. Required response: `rsp_valid` goes to 0 immediately; after release the state is IDLE and port 0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer for the 32-word data memory.
// Port 0 is the core load/store unit, port 1 is debug/DMA. At most one
// request is granted per cycle; responses return one cycle after accept.
// A lock keeps one port as exclusive owner for read-modify-write sequences,
// with an optional idle timeout (LOCK_TIMEOUT = 0 disables it).
// Optional feature macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin contention
// in IDLE instead of fixed port-0 priority).
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 32,
    parameter int LOCK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic              p0_req_lock,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic              p1_req_lock,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              lock_abort
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    // Counter only has to hold 0 .. LOCK_TIMEOUT-1; it clears when it fires.
    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam bit TIMEOUT_EN = (LOCK_TIMEOUT != 0);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               abort_reg, abort_next;

    // Ports gathered into arrays so the datapath can be indexed by port.
    logic [1:0]         req_valid, req_we, req_lock;
    logic [ADDR_W-1:0]  req_addr  [2];
    logic [DATA_W-1:0]  req_wdata [2];
    logic [1:0]         grant;
    logic               accept;
    logic               sel;
    logic               owner_idle;
    logic               timeout_hit;

    assign req_valid    = {p1_req_valid, p0_req_valid};
    assign req_we       = {p1_req_we,    p0_req_we};
    assign req_lock     = {p1_req_lock,  p0_req_lock};
    assign req_addr[0]  = p0_req_addr;
    assign req_addr[1]  = p1_req_addr;
    assign req_wdata[0] = p0_req_wdata;
    assign req_wdata[1] = p1_req_wdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_grant_reg;

    // Remember which port won the most recent accept for round-robin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            last_grant_reg <= sel;
        end
    end
`endif

    // Combinational grant: one-hot or zero, never while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (rst_n) begin
            case (state_reg)
                IDLE: begin
                    if (req_valid == 2'b11) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        grant = last_grant_reg ? 2'b01 : 2'b10;
`else
                        grant = 2'b01;
`endif
                    end else begin
                        grant = req_valid;
                    end
                end
                LOCK0:   grant = {1'b0, req_valid[0]};
                LOCK1:   grant = {req_valid[1], 1'b0};
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept       = |grant;
    assign sel          = grant[1];
    assign p0_req_ready = grant[0];
    assign p1_req_ready = grant[1];

    // Memory ports follow the granted request; everything idles at zero.
    always_comb begin
        mem_we         = 1'b0;
        mem_write_addr = '0;
        mem_write_data = '0;
        mem_read_addr  = '0;
        if (accept) begin
            if (req_we[sel]) begin
                mem_we         = 1'b1;
                mem_write_addr = req_addr[sel];
                mem_write_data = req_wdata[sel];
            end else begin
                mem_read_addr  = req_addr[sel];
            end
        end
    end

    assign owner_idle  = ((state_reg == LOCK0) && !req_valid[0]) ||
                         ((state_reg == LOCK1) && !req_valid[1]);
    assign timeout_hit = TIMEOUT_EN && owner_idle && (cnt_reg == CNT_LAST);

    // Lock state machine and idle counter: next-state logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        abort_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (accept && req_lock[sel]) begin
                    state_next = sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (accept) begin
                    // Owner valid always wins, even on the timeout cycle.
                    cnt_next = '0;
                    if (!req_lock[sel]) begin
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                    abort_next = 1'b1;
                end else if (TIMEOUT_EN) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State, idle counter and abort pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            abort_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            abort_reg <= abort_next;
        end
    end

    assign lock_abort = abort_reg;

    // Per-port response registers: strobe after every accept, data held otherwise.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
        logic              rsp_valid_reg;
        logic [DATA_W-1:0] rsp_rdata_reg;

        // Capture read data (or zero for writes) on this port's accept.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rsp_valid_reg <= 1'b0;
                rsp_rdata_reg <= '0;
            end else begin
                rsp_valid_reg <= grant[gi];
                if (grant[gi]) begin
                    rsp_rdata_reg <= req_we[gi] ? '0 : mem_read_data;
                end
            end
        end
    end

    assign p0_rsp_valid = g_rsp[0].rsp_valid_reg;
    assign p0_rsp_rdata = g_rsp[0].rsp_rdata_reg;
    assign p1_rsp_valid = g_rsp[1].rsp_valid_reg;
    assign p1_rsp_rdata = g_rsp[1].rsp_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. Grants and memory port
// values are checked in the stimulus thread; responses are checked by a
// monitor popping per-port queues of expected read data.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p0_req_valid, p0_req_ready, p0_req_we, p0_req_lock;
    logic [4:0]  p0_req_addr;
    logic [31:0] p0_req_wdata;
    logic        p0_rsp_valid;
    logic [31:0] p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_req_lock;
    logic [4:0]  p1_req_addr;
    logic [31:0] p1_req_wdata;
    logic        p1_rsp_valid;
    logic [31:0] p1_rsp_rdata;
    logic        mem_we;
    logic [4:0]  mem_write_addr, mem_read_addr;
    logic [31:0] mem_write_data, mem_read_data;
    logic        lock_abort;

    int errors = 0;
    int checks = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] mem [32];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(5), .DATA_W(32), .LOCK_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_we(p0_req_we), .p0_req_lock(p0_req_lock),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_we(p1_req_we), .p1_req_lock(p1_req_lock),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
        .mem_we(mem_we), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data), .lock_abort(lock_abort)
    );

    // Memory: preloaded with A500_00nn, combinational read, write at the edge.
    assign mem_read_data = mem[mem_read_addr];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 + 32'(i);
        forever begin
            @(posedge clk);
            if (mem_we) mem[mem_write_addr] <= mem_write_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic set0(input int v, input int we, input int lk, input int a, input logic [31:0] d);
        p0_req_valid = (v != 0);
        p0_req_we    = (we != 0);
        p0_req_lock  = (lk != 0);
        p0_req_addr  = 5'(a);
        p0_req_wdata = d;
    endtask

    task automatic set1(input int v, input int we, input int lk, input int a, input logic [31:0] d);
        p1_req_valid = (v != 0);
        p1_req_we    = (we != 0);
        p1_req_lock  = (lk != 0);
        p1_req_addr  = 5'(a);
        p1_req_wdata = d;
    endtask

    task automatic idle_both;
        set0(0, 0, 0, 0, 32'h0);
        set1(0, 0, 0, 0, 32'h0);
    endtask

    task automatic apply_reset;
        @(negedge clk);
        idle_both();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response monitor: every rsp strobe must match the oldest expectation.
    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (p0_rsp_valid) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL p0_rsp_unexpected: got rdata %h, expected no response", p0_rsp_rdata);
                end else begin
                    exp = q0.pop_front();
                    $display("rsp p0 rdata=%h exp=%h", p0_rsp_rdata, exp);
                    chk("p0_rsp_rdata", p0_rsp_rdata, exp);
                end
            end
            if (p1_rsp_valid) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL p1_rsp_unexpected: got rdata %h, expected no response", p1_rsp_rdata);
                end else begin
                    exp = q1.pop_front();
                    $display("rsp p1 rdata=%h exp=%h", p1_rsp_rdata, exp);
                    chk("p1_rsp_rdata", p1_rsp_rdata, exp);
                end
            end
        end
    end

    initial begin
        int exp_g;
        idle_both();
        // Reset values; a valid request must not be readied during reset.
        p0_req_valid = 1'b1;
        @(posedge clk); #2;
        chkb("reset_p0_ready", p0_req_ready, 1'b0);
        chkb("reset_p1_ready", p1_req_ready, 1'b0);
        chkb("reset_p0_rsp_valid", p0_rsp_valid, 1'b0);
        chk("reset_p0_rsp_rdata", p0_rsp_rdata, 32'h0);
        chkb("reset_mem_we", mem_we, 1'b0);
        chk("reset_mem_read_addr", 32'(mem_read_addr), 32'h0);
        chkb("reset_lock_abort", lock_abort, 1'b0);
        p0_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single-port write then read of addr 3.
        @(negedge clk); set0(1, 1, 0, 3, 32'hDEADBEEF); #1;
        chkb("wr_p0_ready", p0_req_ready, 1'b1);
        chkb("wr_mem_we", mem_we, 1'b1);
        chk("wr_mem_write_addr", 32'(mem_write_addr), 32'd3);
        chk("wr_mem_write_data", mem_write_data, 32'hDEADBEEF);
        q0.push_back(32'h0);
        @(negedge clk); set0(1, 0, 0, 3, 32'h0); #1;
        chkb("rd_p0_ready", p0_req_ready, 1'b1);
        chkb("rd_mem_we", mem_we, 1'b0);
        chk("rd_mem_read_addr", 32'(mem_read_addr), 32'd3);
        q0.push_back(32'hDEADBEEF);
        @(negedge clk); idle_both(); #1;
        chkb("idle_mem_we", mem_we, 1'b0);
        chk("idle_mem_read_addr", 32'(mem_read_addr), 32'h0);
        chk("idle_mem_write_addr", 32'(mem_write_addr), 32'h0);
        @(negedge clk); #1;
        chkb("hold_p0_rsp_valid", p0_rsp_valid, 1'b0);
        chk("hold_p0_rsp_rdata", p0_rsp_rdata, 32'hDEADBEEF);

        // Contention: both ports read every cycle for 4 cycles, from reset.
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set0(1, 0, 0, 1, 32'h0); set1(1, 0, 0, 2, 32'h0); #1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            chkb("cont_p0_ready", p0_req_ready, exp_g == 0);
            chkb("cont_p1_ready", p1_req_ready, exp_g == 1);
            chk("cont_mem_read_addr", 32'(mem_read_addr), (exp_g == 1) ? 32'd2 : 32'd1);
            if (exp_g == 0) q0.push_back(32'hA500_0001);
            else            q1.push_back(32'hA500_0002);
        end
        @(negedge clk); idle_both();

        // Lock exclusion: port 1 locks, port 0 waits until the unlock write.
        @(negedge clk); set1(1, 0, 1, 7, 32'h0); #1;
        chkb("lk_p1_ready", p1_req_ready, 1'b1);
        q1.push_back(32'hA500_0007);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); set1(0, 0, 0, 0, 32'h0); set0(1, 0, 0, 4, 32'h0); #1;
            chkb("lk_p0_blocked", p0_req_ready, 1'b0);
        end
        @(negedge clk); set1(1, 1, 0, 7, 32'h12345678); #1;
        chkb("unlk_p0_blocked", p0_req_ready, 1'b0);
        chkb("unlk_p1_ready", p1_req_ready, 1'b1);
        chkb("unlk_mem_we", mem_we, 1'b1);
        chk("unlk_mem_write_addr", 32'(mem_write_addr), 32'd7);
        q1.push_back(32'h0);
        @(negedge clk); set1(0, 0, 0, 0, 32'h0); #1;
        chkb("unlk_p0_granted", p0_req_ready, 1'b1);
        chk("unlk_p0_read_addr", 32'(mem_read_addr), 32'd4);
        q0.push_back(32'hA500_0004);
        @(negedge clk); idle_both();

        // Lock timeout: abort 17 cycles after the lock accept.
        @(negedge clk); set0(1, 0, 1, 5, 32'h0); #1;
        chkb("to_p0_ready", p0_req_ready, 1'b1);
        q0.push_back(32'hA500_0005);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk); set0(0, 0, 0, 0, 32'h0); set1(1, 0, 0, 6, 32'h0); #1;
            chkb("to_p1_blocked", p1_req_ready, 1'b0);
            chkb("to_abort_early", lock_abort, 1'b0);
        end
        @(negedge clk); #1;
        chkb("to_abort_pulse", lock_abort, 1'b1);
        chkb("to_p1_granted", p1_req_ready, 1'b1);
        q1.push_back(32'hA500_0006);
        @(negedge clk); set1(0, 0, 0, 0, 32'h0); #1;
        chkb("to_abort_cleared", lock_abort, 1'b0);

        // Owner valid on the timeout edge wins: accepted, no abort.
        @(negedge clk); set0(1, 0, 1, 5, 32'h0); #1;
        chkb("tw_p0_ready", p0_req_ready, 1'b1);
        q0.push_back(32'hA500_0005);
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk); set0(0, 0, 0, 0, 32'h0);
        end
        @(negedge clk); set0(1, 0, 0, 1, 32'h0); set1(1, 0, 0, 2, 32'h0); #1;
        chkb("tw_p0_ready_edge", p0_req_ready, 1'b1);
        chkb("tw_p1_blocked_edge", p1_req_ready, 1'b0);
        q0.push_back(32'hA500_0001);
        @(negedge clk); set0(0, 0, 0, 0, 32'h0); #1;
        chkb("tw_no_abort", lock_abort, 1'b0);
        chkb("tw_p1_granted", p1_req_ready, 1'b1);
        q1.push_back(32'hA500_0002);
        @(negedge clk); idle_both();

        // Reset mid-lock with a response pending: response is dropped.
        @(negedge clk); set1(1, 0, 1, 2, 32'h0); #1;
        chkb("rml_p1_ready", p1_req_ready, 1'b1);
        @(posedge clk); #2;
        chkb("rml_rsp_pending", p1_rsp_valid, 1'b1);
        rst_n = 1'b0;
        set1(0, 0, 0, 0, 32'h0);
        #1;
        chkb("rml_rsp_valid_cleared", p1_rsp_valid, 1'b0);
        chk("rml_rsp_rdata_cleared", p1_rsp_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); set0(1, 0, 0, 3, 32'h0); set1(1, 0, 0, 4, 32'h0); #1;
        chkb("rml_p0_first", p0_req_ready, 1'b1);
        chkb("rml_p1_waits", p1_req_ready, 1'b0);
        q0.push_back(32'hDEADBEEF);
        @(negedge clk); idle_both();
        @(negedge clk);
        @(negedge clk); #1;
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
